// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - request/response and data-memory bus bundle for lsu_mem_ctrl
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_rw;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_rw
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_rw
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RISC-V load/store unit with byte-beat splitting of misaligned accesses
// Request -> one native access (or N byte beats) -> one-cycle response; all outputs registered.
module lsu_mem_ctrl #(
    parameter int ADDR_W           = 6,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);
    localparam logic [3:0] RW_SB  = 4'b1011;
    localparam logic [3:0] RW_SH  = 4'b1110;
    localparam logic [3:0] RW_SW  = 4'b1111;
    localparam logic [3:0] RW_LBU = 4'b1100;

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, DONE} state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       result_q, result_d;
    logic [1:0]        beat_q, beat_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_rw_q, mem_rw_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_fault_q, resp_fault_d;

    logic [1:0]        beat_nxt;
    logic [1:0]        beat_last;
    logic [31:0]       merged;
    logic              req_legal;
    logic              req_misaligned;
    logic              unused_addr_hi;

    function automatic logic [3:0] native_code(input logic wr, input logic [2:0] f3);
        if (!wr) return {1'b1, f3};
        case (f3)
            3'b000:  return RW_SB;
            3'b001:  return RW_SH;
            default: return RW_SW;
        endcase
    endfunction

    function automatic logic is_legal(input logic wr, input logic [2:0] f3);
        if (wr) return (f3 <= 3'b010);
        return (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
        case (f3)
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b101:  return {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];
    assign req_legal      = is_legal(bus.req_write, bus.req_funct3);
    assign req_misaligned = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
    assign beat_nxt       = beat_q + 2'd1;
    assign beat_last      = funct3_q[1] ? 2'd3 : 2'd1;

    // Split loads assemble little-endian: the byte returned this beat lands in lane beat_q.
    always_comb begin
        merged                        = result_q;
        merged[{beat_q, 3'b000} +: 8] = bus.mem_rdata[7:0];
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        result_d     = result_q;
        beat_d       = beat_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_rw_d     = '0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_fault_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr[ADDR_W-1:0];
                    wdata_d  = bus.req_wdata;
                    result_d = '0;
                    beat_d   = '0;
                    if (!req_legal || (req_misaligned && !ALLOW_MISALIGNED)) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else if (req_misaligned) begin
                        state_d     = SPLIT;
                        mem_addr_d  = bus.req_addr[ADDR_W-1:0];
                        mem_rw_d    = bus.req_write ? RW_SB : RW_LBU;
                        mem_read_d  = !bus.req_write;
                        mem_write_d = bus.req_write;
                        mem_wdata_d = bus.req_write ? {24'h0, bus.req_wdata[7:0]} : 32'h0;
                    end else begin
                        state_d     = ACCESS;
                        mem_addr_d  = bus.req_addr[ADDR_W-1:0];
                        mem_rw_d    = native_code(bus.req_write, bus.req_funct3);
                        mem_read_d  = !bus.req_write;
                        mem_write_d = bus.req_write;
                        mem_wdata_d = bus.req_write ? bus.req_wdata : 32'h0;
                    end
                end
            end
            ACCESS: begin
                state_d      = DONE;
                resp_valid_d = 1'b1;
                if (!write_q) begin
                    result_d     = bus.mem_rdata;
                    resp_rdata_d = bus.mem_rdata;
                end
            end
            SPLIT: begin
                if (!write_q) result_d = merged;
                if (beat_q == beat_last) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    if (!write_q) resp_rdata_d = extend(merged, funct3_q);
                end else begin
                    beat_d      = beat_nxt;
                    mem_addr_d  = addr_q + ADDR_W'(beat_nxt);
                    mem_rw_d    = write_q ? RW_SB : RW_LBU;
                    mem_read_d  = !write_q;
                    mem_write_d = write_q;
                    mem_wdata_d = write_q ? {24'h0, wdata_q[{beat_nxt, 3'b000} +: 8]} : 32'h0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            result_q     <= '0;
            beat_q       <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rw_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            result_q     <= result_d;
            beat_q       <= beat_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rw_q     <= mem_rw_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_rw     = mem_rw_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_W(6)) bus ();
    lsu_mem_ctrl_if #(.ADDR_W(6)) bus_na ();

    lsu_mem_ctrl #(.ADDR_W(6), .ALLOW_MISALIGNED(1'b1)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
    lsu_mem_ctrl #(.ADDR_W(6), .ALLOW_MISALIGNED(1'b0)) dut_na (.clk(clk), .rst_n(rst_n), .bus(bus_na));

    assign bus_na.mem_rdata = 32'h0;

    // Byte memory model: combinational extended read, write on rising edge
    logic [7:0] mem [64];
    logic [5:0] ma0, ma1, ma2, ma3;
    always_comb begin
        ma0 = bus.mem_addr;
        ma1 = ma0 + 6'd1;
        ma2 = ma0 + 6'd2;
        ma3 = ma0 + 6'd3;
        bus.mem_rdata = 32'h0;
        if (bus.mem_read) begin
            case (bus.mem_rw)
                4'b1000: bus.mem_rdata = {{24{mem[ma0][7]}}, mem[ma0]};
                4'b1001: bus.mem_rdata = {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]};
                4'b1010: bus.mem_rdata = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
                4'b1100: bus.mem_rdata = {24'h0, mem[ma0]};
                4'b1101: bus.mem_rdata = {16'h0, mem[ma1], mem[ma0]};
                default: bus.mem_rdata = 32'h0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (bus.mem_write) begin
            case (bus.mem_rw)
                4'b1011: mem[ma0] <= bus.mem_wdata[7:0];
                4'b1110: begin mem[ma0] <= bus.mem_wdata[7:0]; mem[ma1] <= bus.mem_wdata[15:8]; end
                4'b1111: begin
                    mem[ma0] <= bus.mem_wdata[7:0];   mem[ma1] <= bus.mem_wdata[15:8];
                    mem[ma2] <= bus.mem_wdata[23:16]; mem[ma3] <= bus.mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    int   acc_cnt  = 0;
    int   junk_cnt = 0;
    int   dbl_cnt  = 0;
    logic prev_rv  = 1'b0;
    always @(posedge clk) if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
    always @(negedge clk) begin
        if (!bus.mem_read && !bus.mem_write && (bus.mem_addr != 6'd0 || bus.mem_rw != 4'd0 || bus.mem_wdata != 32'd0))
            junk_cnt <= junk_cnt + 1;
        if (prev_rv && bus.resp_valid) dbl_cnt <= dbl_cnt + 1;
        prev_rv <= bus.resp_valid;
    end

    int          r_lat;
    logic [31:0] r_data;
    logic        r_fault;
    logic        r_after;
    int          nb;
    logic [5:0]  b_addr [8];
    logic [3:0]  b_rw   [8];
    logic [31:0] b_wd   [8];
    logic        b_rd   [8];
    logic        b_wr   [8];

    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        nb = 0; r_lat = -1; r_data = 32'h0; r_fault = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (bus.mem_read || bus.mem_write) begin
                if (nb < 8) begin
                    b_addr[nb] = bus.mem_addr; b_rw[nb] = bus.mem_rw; b_wd[nb] = bus.mem_wdata;
                    b_rd[nb] = bus.mem_read; b_wr[nb] = bus.mem_write;
                end
                nb++;
            end
            if (bus.resp_valid) begin r_lat = c; r_data = bus.resp_rdata; r_fault = bus.resp_fault; break; end
            @(negedge clk);
        end
        @(negedge clk);
        r_after = bus.resp_valid;
    endtask

    int          na_lat;
    logic [31:0] na_data;
    logic        na_fault;
    int          na_strb;

    task automatic na_req(input logic [2:0] f3, input logic [31:0] addr);
        repeat (2) @(negedge clk);
        bus_na.req_valid = 1'b1; bus_na.req_write = 1'b0; bus_na.req_funct3 = f3; bus_na.req_addr = addr;
        @(negedge clk);
        bus_na.req_valid = 1'b0;
        na_lat = -1; na_data = 32'h0; na_fault = 1'b0; na_strb = 0;
        for (int c = 1; c <= 8; c++) begin
            if (bus_na.mem_read || bus_na.mem_write) na_strb++;
            if (bus_na.resp_valid) begin na_lat = c; na_data = bus_na.resp_rdata; na_fault = bus_na.resp_fault; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        n_cmp++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes: got %b want 00", {bus.mem_read, bus.mem_write}); end
        n_cmp++; if ({bus.mem_addr, bus.mem_rw, bus.mem_wdata} !== 42'h0) begin n_fail++; $display("FAIL rst_mem_bus: got %h want 0", {bus.mem_addr, bus.mem_rw, bus.mem_wdata}); end
        n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
        n_cmp++; if (bus_na.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_na_ready: got %b want 1", bus_na.req_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_aligned();
        do_req(1'b1, 3'b010, 32'd0, 32'h0000_0011);
        n_cmp++; if (r_lat !== 2) begin n_fail++; $display("FAIL sw0_latency: got %0d want 2", r_lat); end
        n_cmp++; if (nb !== 1) begin n_fail++; $display("FAIL sw0_beats: got %0d want 1", nb); end
        n_cmp++; if ({b_wr[0], b_rw[0]} !== 5'b1_1111) begin n_fail++; $display("FAIL sw0_code: got %b want 11111", {b_wr[0], b_rw[0]}); end
        n_cmp++; if (b_wd[0] !== 32'h11) begin n_fail++; $display("FAIL sw0_wdata: got %h want 00000011", b_wd[0]); end
        n_cmp++; if ({r_fault, r_data} !== 33'h0) begin n_fail++; $display("FAIL sw0_resp: got %h want 0", {r_fault, r_data}); end
        do_req(1'b0, 3'b010, 32'd0, 32'h0);
        n_cmp++; if ({b_rd[0], b_rw[0], b_addr[0]} !== {1'b1, 4'b1010, 6'd0}) begin n_fail++; $display("FAIL lw0_access: got %b want 1_1010_000000", {b_rd[0], b_rw[0], b_addr[0]}); end
        n_cmp++; if (r_lat !== 2) begin n_fail++; $display("FAIL lw0_latency: got %0d want 2", r_lat); end
        n_cmp++; if (r_data !== 32'h0000_0011) begin n_fail++; $display("FAIL lw0_rdata: got %h want 00000011", r_data); end
        n_cmp++; if (r_fault !== 1'b0) begin n_fail++; $display("FAIL lw0_fault: got %b want 0", r_fault); end
        n_cmp++; if (r_after !== 1'b0) begin n_fail++; $display("FAIL lw0_single_pulse: got %b want 0", r_after); end
    endtask

    task automatic test_split_half();
        do_req(1'b1, 3'b001, 32'd5, 32'h0000_8081);
        n_cmp++; if (nb !== 2) begin n_fail++; $display("FAIL sh5_beats: got %0d want 2", nb); end
        n_cmp++; if ({b_addr[0], b_rw[0], b_wd[0]} !== {6'd5, 4'b1011, 32'h81}) begin n_fail++; $display("FAIL sh5_beat0: got %h want %h", {b_addr[0], b_rw[0], b_wd[0]}, {6'd5, 4'b1011, 32'h81}); end
        n_cmp++; if ({b_addr[1], b_rw[1], b_wd[1]} !== {6'd6, 4'b1011, 32'h80}) begin n_fail++; $display("FAIL sh5_beat1: got %h want %h", {b_addr[1], b_rw[1], b_wd[1]}, {6'd6, 4'b1011, 32'h80}); end
        n_cmp++; if (r_lat !== 3) begin n_fail++; $display("FAIL sh5_latency: got %0d want 3", r_lat); end
        do_req(1'b0, 3'b001, 32'd5, 32'h0);
        n_cmp++; if ({b_rd[0], b_rw[0], b_addr[0], b_rw[1], b_addr[1]} !== {1'b1, 4'b1100, 6'd5, 4'b1100, 6'd6}) begin n_fail++; $display("FAIL lh5_beats: got %h", {b_rd[0], b_rw[0], b_addr[0], b_rw[1], b_addr[1]}); end
        n_cmp++; if (r_lat !== 3) begin n_fail++; $display("FAIL lh5_latency: got %0d want 3", r_lat); end
        n_cmp++; if (r_data !== 32'hFFFF_8081) begin n_fail++; $display("FAIL lh5_rdata: got %h want ffff8081", r_data); end
        do_req(1'b0, 3'b101, 32'd5, 32'h0);
        n_cmp++; if (r_data !== 32'h0000_8081) begin n_fail++; $display("FAIL lhu5_rdata: got %h want 00008081", r_data); end
        n_cmp++; if (r_lat !== 3) begin n_fail++; $display("FAIL lhu5_latency: got %0d want 3", r_lat); end
    endtask

    task automatic test_wrap();
        do_req(1'b1, 3'b010, 32'd62, 32'hA1B2_C3D4);
        n_cmp++; if (nb !== 4) begin n_fail++; $display("FAIL sw62_beats: got %0d want 4", nb); end
        n_cmp++; if ({b_addr[0], b_addr[1], b_addr[2], b_addr[3]} !== {6'd62, 6'd63, 6'd0, 6'd1}) begin n_fail++; $display("FAIL sw62_addrs: got %0d %0d %0d %0d want 62 63 0 1", b_addr[0], b_addr[1], b_addr[2], b_addr[3]); end
        n_cmp++; if ({b_wd[0][7:0], b_wd[1][7:0], b_wd[2][7:0], b_wd[3][7:0]} !== 32'hD4C3_B2A1) begin n_fail++; $display("FAIL sw62_bytes: got %h want d4c3b2a1", {b_wd[0][7:0], b_wd[1][7:0], b_wd[2][7:0], b_wd[3][7:0]}); end
        n_cmp++; if (r_lat !== 5) begin n_fail++; $display("FAIL sw62_latency: got %0d want 5", r_lat); end
        do_req(1'b0, 3'b010, 32'd62, 32'h0);
        n_cmp++; if (r_data !== 32'hA1B2_C3D4) begin n_fail++; $display("FAIL lw62_rdata: got %h want a1b2c3d4", r_data); end
        n_cmp++; if (r_lat !== 5) begin n_fail++; $display("FAIL lw62_latency: got %0d want 5", r_lat); end
        do_req(1'b0, 3'b001, 32'd63, 32'h0);
        n_cmp++; if ({b_addr[0], b_addr[1]} !== {6'd63, 6'd0}) begin n_fail++; $display("FAIL lh63_addrs: got %0d %0d want 63 0", b_addr[0], b_addr[1]); end
        n_cmp++; if (r_data !== 32'hFFFF_B2C3) begin n_fail++; $display("FAIL lh63_rdata: got %h want ffffb2c3", r_data); end
    endtask

    task automatic test_faults();
        do_req(1'b0, 3'b011, 32'd8, 32'h0);
        n_cmp++; if (r_lat !== 1) begin n_fail++; $display("FAIL ld011_latency: got %0d want 1", r_lat); end
        n_cmp++; if ({r_fault, r_data} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL ld011_resp: got %h want 100000000", {r_fault, r_data}); end
        n_cmp++; if (nb !== 0) begin n_fail++; $display("FAIL ld011_strobes: got %0d want 0", nb); end
        do_req(1'b1, 3'b100, 32'd8, 32'hFFFF_FFFF);
        n_cmp++; if ({r_lat, r_fault, nb} !== {32'd1, 1'b1, 32'd0}) begin n_fail++; $display("FAIL st100: lat %0d fault %b beats %0d want 1 1 0", r_lat, r_fault, nb); end
        na_req(3'b010, 32'd2);
        n_cmp++; if (na_lat !== 1) begin n_fail++; $display("FAIL na_lw2_latency: got %0d want 1", na_lat); end
        n_cmp++; if ({na_fault, na_data} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL na_lw2_resp: got %h want 100000000", {na_fault, na_data}); end
        n_cmp++; if (na_strb !== 0) begin n_fail++; $display("FAIL na_lw2_strobes: got %0d want 0", na_strb); end
        na_req(3'b010, 32'd4);
        n_cmp++; if ({na_lat, na_fault, na_strb} !== {32'd2, 1'b0, 32'd1}) begin n_fail++; $display("FAIL na_lw4: lat %0d fault %b strobes %0d want 2 0 1", na_lat, na_fault, na_strb); end
    endtask

    task automatic test_reset_midsplit();
        int rv_seen;
        int st_seen;
        do_req(1'b1, 3'b000, 32'd60, 32'h0000_009C);
        n_cmp++; if ({r_lat, b_rw[0]} !== {32'd2, 4'b1011}) begin n_fail++; $display("FAIL sb60: lat %0d code %b want 2 1011", r_lat, b_rw[0]); end
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'd61; bus.req_wdata = 32'h1122_3344;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_cmp++; if ({bus.mem_write, bus.mem_addr, bus.mem_wdata} !== {1'b1, 6'd61, 32'h44}) begin n_fail++; $display("FAIL sw61_beat0: got %h want %h", {bus.mem_write, bus.mem_addr, bus.mem_wdata}, {1'b1, 6'd61, 32'h44}); end
        @(negedge clk);
        n_cmp++; if (bus.mem_addr !== 6'd62) begin n_fail++; $display("FAIL sw61_beat1_addr: got %0d want 62", bus.mem_addr); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_rw, bus.mem_wdata, bus.resp_valid} !== 45'h0) begin n_fail++; $display("FAIL midrst_outputs: got %h want 0", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_rw, bus.mem_wdata, bus.resp_valid}); end
        @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 0; st_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) rv_seen++;
            if (bus.mem_read || bus.mem_write) st_seen++;
        end
        n_cmp++; if ({rv_seen, st_seen} !== 64'h0) begin n_fail++; $display("FAIL midrst_quiet: resp %0d strobes %0d want 0 0", rv_seen, st_seen); end
        n_cmp++; if ({mem[61], mem[62], mem[63]} !== 24'h44D4C3) begin n_fail++; $display("FAIL midrst_mem: got %h want 44d4c3", {mem[61], mem[62], mem[63]}); end
        do_req(1'b0, 3'b000, 32'd60, 32'h0);
        n_cmp++; if ({r_lat, r_fault, b_rw[0]} !== {32'd2, 1'b0, 4'b1000}) begin n_fail++; $display("FAIL lb60: lat %0d fault %b code %b want 2 0 1000", r_lat, r_fault, b_rw[0]); end
        n_cmp++; if (r_data !== 32'hFFFF_FF9C) begin n_fail++; $display("FAIL lb60_rdata: got %h want ffffff9c", r_data); end
    endtask

    task automatic test_back_to_back();
        int          acc0;
        int          n_acc;
        int          n_rsp;
        int          acc_c [3];
        int          rsp_c [3];
        logic [31:0] rsp_d [3];
        logic [31:0] addrs [3];
        logic [31:0] want  [3];
        addrs = '{32'd5, 32'd6, 32'd61};
        want  = '{32'h81, 32'h80, 32'h44};
        acc0 = acc_cnt; n_acc = 0; n_rsp = 0;
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            if (bus.resp_valid) begin
                if (n_rsp < 3) begin rsp_c[n_rsp] = c; rsp_d[n_rsp] = bus.resp_rdata; end
                n_rsp++;
            end
            if (bus.req_ready && n_acc < 3) begin
                bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b100; bus.req_addr = addrs[n_acc];
                acc_c[n_acc] = c;
                n_acc++;
            end else if (n_acc == 3) begin
                bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++; if (acc_cnt - acc0 !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 3", acc_cnt - acc0); end
        n_cmp++; if (n_rsp !== 3) begin n_fail++; $display("FAIL b2b_responses: got %0d want 3", n_rsp); end
        if (n_rsp == 3 && n_acc == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (rsp_d[i] !== want[i]) begin n_fail++; $display("FAIL b2b_rdata%0d: got %h want %h", i, rsp_d[i], want[i]); end
                n_cmp++; if (rsp_c[i] - acc_c[i] !== 2) begin n_fail++; $display("FAIL b2b_latency%0d: got %0d want 2", i, rsp_c[i] - acc_c[i]); end
            end
            for (int i = 0; i < 2; i++) begin
                n_cmp++; if (rsp_c[i+1] - rsp_c[i] !== 3) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 3", i, rsp_c[i+1] - rsp_c[i]); end
            end
        end
        n_cmp++; if (dbl_cnt !== 0) begin n_fail++; $display("FAIL resp_multi_cycle: got %0d want 0", dbl_cnt); end
        n_cmp++; if (junk_cnt !== 0) begin n_fail++; $display("FAIL idle_bus_nonzero: got %0d want 0", junk_cnt); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus_na.req_valid = 1'b0; bus_na.req_write = 1'b0; bus_na.req_funct3 = 3'b0; bus_na.req_addr = 32'h0; bus_na.req_wdata = 32'h0;
        test_reset();
        test_aligned();
        test_split_half();
        test_wrap();
        test_faults();
        test_reset_midsplit();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
